gate2_seq_ctrl: RTL
===================

// Module: gate2_seq_ctrl
// PURPOSE
//   Self-test sequencer for the 2-input gate bank (gate2: inputs a, b; output z[5:0]).
//   On start, drives a/b through the four input vectors in fixed order and samples z after a settle time.
//   Compares each sample against the expected truth table and reports pass/fail with a done pulse.
//   Replaces the manual stimulus bench so the gate bank can be checked on the board.
// PARAMETERS
//   SETTLE_CYCLES  2   cycles between driving a vector and sampling z; legal range >= 1
//   HOLD_CYCLES    20  cycles each vector is held after its sample; legal range >= 1
// PORTS
//   clk        in   1  single clock, rising edge
//   clr_n      in   1  asynchronous active-low reset
//   start      in   1  level; sampled only in IDLE; begins a run
//   a_out      out  1  drives gate2.a
//   b_out      out  1  drives gate2.b
//   z_in       in   6  from gate2.z; bit order: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
//   busy       out  1  high from the cycle after start is accepted until done
//   vec_idx    out  2  index of the current vector (0..3)
//   done       out  1  one-cycle pulse at end of run
//   pass       out  1  valid while done is high and held afterwards; 1 = all 4 vectors matched
//   err_mask   out  6  OR of (z_in ^ expected) over the run; held until the next start
//   fail_valid out  1  [ERRLOG only] first mismatch captured
//   fail_vec   out  2  [ERRLOG only] vec_idx of the first mismatch
//   fail_z     out  6  [ERRLOG only] z_in sampled at the first mismatch
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; a_out=b_out=0; busy=0; vec_idx=0; done=0; pass=0; err_mask=0; fail_*=0.
//   Vector table {a,b} by vec_idx: 0:00  1:10  2:01  3:11.
//   Expected z by vector:
//     00 -> 6'h2A
//     10 -> 6'h16
//     01 -> 6'h16
//     11 -> 6'h25
//   FSM: IDLE -> SETTLE -> CHECK -> HOLD -> (SETTLE for the next vector | DONE) -> IDLE.
//     IDLE:   start=1 at edge k. Go to SETTLE with vec_idx=0. Drive a/b from cycle k+1.
//             Clear err_mask, pass and fail_*. Set busy.
//     SETTLE: stay SETTLE_CYCLES cycles; a_out/b_out are stable.
//     CHECK:  1 cycle. err_mask |= z_in ^ exp[vec_idx]. A mismatch in this vector is z_in != exp.
//     HOLD:   stay HOLD_CYCLES cycles.
//             At the end, if vec_idx<3: increment vec_idx, drive the new vector and go to SETTLE.
//             Otherwise go to DONE.
//     DONE:   1 cycle. done=1, busy=0, pass=(err_mask==0). Then IDLE.
//             vec_idx returns to 0; a_out/b_out return to 0.
//   Latency: done is high in cycle k+1+4*(SETTLE_CYCLES+1+HOLD_CYCLES).
//   Start is ignored while busy or during DONE; there is no queueing.
//   A start held high re-triggers from IDLE on the cycle after DONE.
//   The cycle counter reloads on every state entry. It never wraps across states.
//   Reset mid-run aborts immediately: no done pulse, and pass stays 0.
// CONFIGURATION
//   `GATE2_SEQ_ERRLOG_EN defined:
//     - on the first CHECK with a mismatch in a run, latch fail_valid=1, fail_vec=vec_idx, fail_z=z_in;
//     - later mismatches do not overwrite the latch;
//     - the latch is cleared on start.
//   Not defined: the fail_* ports are absent. err_mask/pass behaviour is identical.
// STRUCTURE
//   gate2_defs.vh (shared `include):
//     - state encodings (IDLE, SETTLE, CHECK, HOLD, DONE);
//     - vector table and expected-z localparams;
//     - z bit-index names.
//   Sub-module gate2_seq_timer: loadable down-counter.
//     Ports: clk, clr_n, load, load_val, expire.
//     Width = clog2(max(SETTLE_CYCLES, HOLD_CYCLES)+1).
//   Top level holds the FSM, vec_idx, the compare logic and the result registers.
// TESTING (SETTLE_CYCLES=2, HOLD_CYCLES=3, clean gate2 instance)
//   1. Reset, then a 1-cycle start pulse:
//      - a/b sequence 00, 10, 01, 11, each held 6 cycles;
//      - done at start+25; pass=1; err_mask=0.
//   2. Stuck-at fault, model forces z[4]=0:
//      - done, pass=0, err_mask=6'h10;
//      - ERRLOG: fail_vec=1, fail_z=6'h06.
//   3. Start pulsed again at cycle 5 of a run -> ignored; single done at start+25.
//   4. clr_n low at cycle 10 of a run:
//      - all outputs 0 immediately; no done;
//      - a following start runs cleanly with pass=1.
//   5. start held high continuously -> done pulses every 26 cycles, each with pass=1.
//   6. Expected-table check: probe each CHECK cycle -> z_in equals 2A, 16, 16, 25 in order.

Source files
------------

// File: rtl/gate2_seq_ctrl_pkg.sv
// Shared definitions for the gate2 self-test sequencer.
//   - FSM state encoding
//   - z bit-index names for the gate bank outputs
//   - vector table ({a,b} per vector index) and expected z per vector
package gate2_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bit positions within gate2.z
    localparam int Z_AND  = 0;
    localparam int Z_NAND = 1;
    localparam int Z_OR   = 2;
    localparam int Z_NOR  = 3;
    localparam int Z_XOR  = 4;
    localparam int Z_XNOR = 5;

    localparam logic [1:0] LAST_VEC = 2'd3;

    // Vector table, returned as {a,b}: 0:00 1:10 2:01 3:11
    function automatic logic [1:0] vec_ab(input logic [1:0] idx);
        case (idx)
            2'd0:    vec_ab = 2'b00;
            2'd1:    vec_ab = 2'b10;
            2'd2:    vec_ab = 2'b01;
            default: vec_ab = 2'b11;
        endcase
    endfunction

    // Expected z for each vector of the table above
    function automatic logic [5:0] exp_z(input logic [1:0] idx);
        case (idx)
            2'd0:    exp_z = 6'h2A;
            2'd1:    exp_z = 6'h16;
            2'd2:    exp_z = 6'h16;
            default: exp_z = 6'h25;
        endcase
    endfunction

endpackage

// File: rtl/gate2_seq_timer.sv
// Loadable down-counter used to time the SETTLE and HOLD phases.
//   clk      in  rising-edge clock
//   clr_n    in  asynchronous active-low reset
//   load     in  load load_val on this edge (takes priority over counting)
//   load_val in  value loaded; the phase lasts load_val+1 cycles
//   expire   out high while the count is zero
module gate2_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            // Saturates at zero so the count never wraps into the next phase
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expire = (count_reg == '0);

endmodule

// File: rtl/gate2_seq_ctrl.sv
// Self-test sequencer for the 2-input gate bank. On start it walks a/b
// through the four input vectors, samples z after SETTLE_CYCLES, compares
// against the truth table, holds each vector HOLD_CYCLES, then pulses done
// with pass / err_mask.
// Optional first-failure log: define GATE2_SEQ_ERRLOG_EN to add the
// fail_valid / fail_vec / fail_z ports.
// Ports:
//   clk, clr_n        clock, asynchronous active-low reset
//   start             level, sampled only in IDLE
//   a_out, b_out      drive gate2.a / gate2.b
//   z_in[5:0]         gate2.z (AND, NAND, OR, NOR, XOR, XNOR from bit 0)
//   busy              run in progress (not during DONE)
//   vec_idx[1:0]      current vector index
//   done              one-cycle end-of-run pulse
//   pass              all vectors matched; held until next start
//   err_mask[5:0]     accumulated mismatching z bits
module gate2_seq_ctrl
    import gate2_seq_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 20
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic [5:0] z_in,
    output logic       busy,
    output logic [1:0] vec_idx,
    output logic       done,
    output logic       pass,
`ifdef GATE2_SEQ_ERRLOG_EN
    output logic       fail_valid,
    output logic [1:0] fail_vec,
    output logic [5:0] fail_z,
`endif
    output logic [5:0] err_mask
);

    localparam int MAX_CYC = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_reg;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_expire;
    logic [5:0]       z_diff;
    logic [1:0]       vec_next;

    assign z_diff   = z_in ^ exp_z(vec_idx);
    assign vec_next = 2'(vec_idx + 2'd1);

    // Timer is reloaded on every transition into a timed phase
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state_reg)
            ST_IDLE: begin
                tmr_load     = start;
                tmr_load_val = SETTLE_LOAD;
            end
            ST_CHECK: begin
                tmr_load     = 1'b1;
                tmr_load_val = HOLD_LOAD;
            end
            ST_HOLD: begin
                tmr_load     = tmr_expire && (vec_idx != LAST_VEC);
                tmr_load_val = SETTLE_LOAD;
            end
            default: begin
                tmr_load     = 1'b0;
                tmr_load_val = '0;
            end
        endcase
    end

    gate2_seq_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg  <= ST_IDLE;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            vec_idx    <= 2'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_mask   <= 6'h00;
`ifdef GATE2_SEQ_ERRLOG_EN
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
            fail_z     <= 6'h00;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg      <= ST_SETTLE;
                        vec_idx        <= 2'd0;
                        {a_out, b_out} <= vec_ab(2'd0);
                        busy           <= 1'b1;
                        pass           <= 1'b0;
                        err_mask       <= 6'h00;
`ifdef GATE2_SEQ_ERRLOG_EN
                        fail_valid     <= 1'b0;
                        fail_vec       <= 2'd0;
                        fail_z         <= 6'h00;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (tmr_expire) begin
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state_reg <= ST_HOLD;
                    err_mask  <= err_mask | z_diff;
`ifdef GATE2_SEQ_ERRLOG_EN
                    // Only the first mismatching vector of a run is logged
                    if ((z_diff != 6'h00) && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec_idx;
                        fail_z     <= z_in;
                    end
`endif
                end
                ST_HOLD: begin
                    if (tmr_expire) begin
                        if (vec_idx != LAST_VEC) begin
                            state_reg      <= ST_SETTLE;
                            vec_idx        <= vec_next;
                            {a_out, b_out} <= vec_ab(vec_next);
                        end else begin
                            state_reg      <= ST_DONE;
                            done           <= 1'b1;
                            busy           <= 1'b0;
                            pass           <= (err_mask == 6'h00);
                            vec_idx        <= 2'd0;
                            a_out          <= 1'b0;
                            b_out          <= 1'b0;
                        end
                    end
                end
                default: begin
                    // DONE: start is ignored here; back to IDLE next cycle
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
